fc_sequencer: RTL and testbench

Frame controller for the fully-connected output stage. It accepts feature values one per beat over a valid/ready stream and packs N_IN of them into the parallel vector the FC datapath consumes. It then fires the datapath with a single-cycle enable, waits the datapath latency, and presents the captured result on a valid/ready output. It sits between the last pooling stage's serial output and the FC unit, and is the only driver of the FC unit's enable and data inputs.

---
 rtl/fc_sequencer.sv | 115 +++++++++++
 tb/tb_fc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_sequencer.sv
// Frame controller for the FC output stage: packs N_IN serial features into a
// parallel vector, fires the FC datapath, waits its latency and returns the result.
module fc_sequencer #(
    parameter int N_IN   = 16,
    parameter int DATA_W = 10,
    parameter int RES_W  = 32,
    parameter int FC_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    input  logic [DATA_W-1:0]      i_in_data,
    input  logic                   i_in_last,
    output logic                   o_in_ready,
    output logic                   o_fc_enable,
    output logic [N_IN*DATA_W-1:0] o_fc_data,
    input  logic [RES_W-1:0]       i_fc_result,
    output logic                   o_out_valid,
    output logic [RES_W-1:0]       o_out_result,
    input  logic                   i_out_ready,
    output logic                   o_frame_err,
    output logic                   o_busy
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = (FC_LAT > 1) ? $clog2(FC_LAT) : 1;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FIRE    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    logic [1:0]             state;
    logic [IDX_W-1:0]       idx;
    logic [CNT_W-1:0]       wait_cnt;
    logic [N_IN*DATA_W-1:0] fc_buf;

    logic accept;
    logic last_slot;
    logic close_frame;
    logic bad_frame;
    logic capture;
    logic out_done;

    // Ready is gated by reset so no beat can be taken while reset is held.
    assign o_in_ready  = (state == ST_COLLECT) & ~i_reset;
    assign accept      = i_in_valid & o_in_ready;
    assign last_slot   = (idx == IDX_W'(N_IN - 1));
    assign close_frame = accept & (last_slot | i_in_last);
    // A well-formed frame ends exactly on the final slot with last set.
    assign bad_frame   = close_frame & ~(last_slot & i_in_last);
    assign capture     = (state == ST_WAIT) && (wait_cnt == '0);
    assign out_done    = (state == ST_OUT) && i_out_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_COLLECT;
            idx         <= '0;
            wait_cnt    <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= bad_frame;
            case (state)
                ST_COLLECT: begin
                    if (accept) begin
                        idx <= close_frame ? '0 : idx + IDX_W'(1);
                    end
                    if (close_frame) begin
                        state <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    wait_cnt <= CNT_W'(FC_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_OUT;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    // Buffer is cleared after each delivered result so short frames read as zero-padded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fc_buf       <= '0;
            o_out_result <= '0;
        end else begin
            if (accept) begin
                fc_buf[int'(idx)*DATA_W +: DATA_W] <= i_in_data;
            end else if (out_done) begin
                fc_buf <= '0;
            end
            if (capture) begin
                o_out_result <= i_fc_result;
            end
        end
    end

    assign o_fc_enable = (state == ST_FIRE);
    assign o_fc_data   = fc_buf;
    assign o_out_valid = (state == ST_OUT);
    assign o_busy      = (state != ST_COLLECT);

endmodule

// File: tb/tb_fc_sequencer.sv
// Randomized self-checking bench for fc_sequencer; two instances (FC_LAT 1 and 4)
// share the stimulus, selected by sel, and are checked against a frame-level model.
module tb_fc_sequencer;

    localparam int N_IN = 16;
    localparam int DW   = 10;
    localparam int RW   = 32;
    localparam int VW   = N_IN * DW;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_last, out_ready, sel, stub_fixed;
    logic [DW-1:0] in_data;

    logic          rdy1, en1, vld1, err1, busy1;
    logic          rdy4, en4, vld4, err4, busy4;
    logic [VW-1:0] fd1, fd4;
    logic [RW-1:0] res1, res4, out1, out4;

    logic          in_ready, fc_en, out_valid, frame_err, busy;
    logic [VW-1:0] fc_data;
    logic [RW-1:0] out_result;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fc_sequencer #(.N_IN(N_IN), .DATA_W(DW), .RES_W(RW), .FC_LAT(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid & ~sel), .i_in_data(in_data),
        .i_in_last(in_last), .o_in_ready(rdy1), .o_fc_enable(en1), .o_fc_data(fd1),
        .i_fc_result(res1), .o_out_valid(vld1), .o_out_result(out1), .i_out_ready(out_ready),
        .o_frame_err(err1), .o_busy(busy1)
    );

    fc_sequencer #(.N_IN(N_IN), .DATA_W(DW), .RES_W(RW), .FC_LAT(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid & sel), .i_in_data(in_data),
        .i_in_last(in_last), .o_in_ready(rdy4), .o_fc_enable(en4), .o_fc_data(fd4),
        .i_fc_result(res4), .o_out_valid(vld4), .o_out_result(out4), .i_out_ready(out_ready),
        .o_frame_err(err4), .o_busy(busy4)
    );

    assign in_ready   = sel ? rdy4  : rdy1;
    assign fc_en      = sel ? en4   : en1;
    assign out_valid  = sel ? vld4  : vld1;
    assign frame_err  = sel ? err4  : err1;
    assign busy       = sel ? busy4 : busy1;
    assign fc_data    = sel ? fd4   : fd1;
    assign out_result = sel ? out4  : out1;

    function automatic logic [RW-1:0] fc_func(input logic [VW-1:0] v);
        logic [RW-1:0] s;
        s = 32'hA5A5_0000;
        for (int k = 0; k < N_IN; k++) s = s + RW'((k + 1) * int'(v[k*DW +: DW]));
        return s;
    endfunction

    // FC stubs: garbage until LAT cycles after enable, then the computed value.
    int cnt1 = 0;
    int cnt4 = 0;
    logic [RW-1:0] val1, val4, junk1, junk4;
    always @(posedge clk) begin
        junk1 <= $urandom;
        junk4 <= $urandom;
        if (en1) begin
            cnt1 <= 1;
            val1 <= stub_fixed ? 32'h0000_1234 : fc_func(fd1);
        end else if (cnt1 != 0 && cnt1 < 1) cnt1 <= cnt1 + 1;
        if (en4) begin
            cnt4 <= 1;
            val4 <= stub_fixed ? 32'h0000_1234 : fc_func(fd4);
        end else if (cnt4 != 0 && cnt4 < 4) cnt4 <= cnt4 + 1;
    end
    assign res1 = (cnt1 == 1) ? val1 : junk1;
    assign res4 = (cnt4 == 4) ? val4 : junk4;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beat stream and the frames the model derives from it.
    logic [DW-1:0] beat_d[$];
    logic          beat_l[$];
    logic [VW-1:0] fr_vec[$];
    int            fr_n[$];
    logic          fr_err[$];

    task automatic add_beat(input logic [DW-1:0] d, input logic l);
        beat_d.push_back(d);
        beat_l.push_back(l);
    endtask

    task automatic build_frames();
        logic [VW-1:0] v;
        int c;
        v = '0;
        c = 0;
        for (int i = 0; i < beat_d.size(); i++) begin
            v[c*DW +: DW] = beat_d[i];
            c++;
            if (c == N_IN || beat_l[i]) begin
                fr_vec.push_back(v);
                fr_n.push_back(c);
                fr_err.push_back(!(c == N_IN && beat_l[i]));
                v = '0;
                c = 0;
            end
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("ready_timeout", 0, 1);
    endtask

    task automatic gen_random(input int nb);
        for (int i = 0; i < nb; i++)
            add_beat(DW'($urandom_range(0, 1023)), (i == nb - 1) || ($urandom_range(0, 5) == 0));
    endtask

    // hold < 0 picks a random backpressure length per frame.
    task automatic run_frames(input int lat, input int hold_arg);
        int bi, n, hold;
        logic [VW-1:0] vec;
        logic [RW-1:0] expres;
        logic e;
        bi = 0;
        build_frames();
        while (fr_n.size() > 0) begin
            vec  = fr_vec.pop_front();
            n    = fr_n.pop_front();
            e    = fr_err.pop_front();
            hold = (hold_arg < 0) ? $urandom_range(0, 3) : hold_arg;
            expres = stub_fixed ? 32'h0000_1234 : fc_func(vec);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                in_valid = 1'b1;
                in_data  = beat_d[bi];
                in_last  = beat_l[bi];
                wait_ready();
                check("collect_en", fc_en, 0);
                @(negedge clk);
                bi++;
            end
            if (bi < beat_d.size()) begin
                in_data = beat_d[bi];
                in_last = beat_l[bi];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (hold == 0);
            check("fire_en", fc_en, 1);
            check("fire_err", frame_err, e);
            check("fire_vec", fc_data, vec);
            check("fire_ready", in_ready, 0);
            check("fire_busy", busy, 1);
            for (int w = 0; w < lat; w++) begin
                @(negedge clk);
                check("wait_en", fc_en, 0);
                check("wait_vld", out_valid, 0);
                check("wait_err", frame_err, 0);
            end
            @(negedge clk);
            check("out_vld", out_valid, 1);
            check("out_result", out_result, expres);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("bp_vld", out_valid, 1);
                check("bp_result", out_result, expres);
                check("bp_ready", in_ready, 0);
                check("bp_en", fc_en, 0);
                check("bp_vec", fc_data, vec);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("post_ready", in_ready, 1);
            check("post_vld", out_valid, 0);
            check("post_busy", busy, 0);
            check("post_clear", fc_data, 0);
        end
        in_valid = 1'b0;
        beat_d.delete();
        beat_l.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b0; sel = 1'b0; stub_fixed = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_en", fc_en, 0);
        check("rst_vld", out_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_result", out_result, 0);
        check("rst_data", fc_data, 0);
        rst = 1'b0;
        #1 check("rel_ready", in_ready, 1);
        @(negedge clk);

        // Full frame 1..16 with fixed stub result
        stub_fixed = 1'b1;
        for (int i = 0; i < N_IN; i++) add_beat(DW'(i + 1), i == N_IN - 1);
        run_frames(1, 0);
        stub_fixed = 1'b0;

        // Short frame
        for (int i = 0; i < 5; i++) add_beat(10'h3FF, i == 4);
        run_frames(1, 0);

        // Missing last followed by a good frame
        for (int i = 0; i < 2 * N_IN; i++) add_beat(DW'($urandom_range(0, 1023)), i == 2 * N_IN - 1);
        run_frames(1, 1);

        // Long backpressure
        gen_random(N_IN);
        run_frames(1, 20);

        // Reset mid-frame
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = DW'(900 + i); in_last = 1'b0;
            wait_ready();
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check("mid_rst_ready", in_ready, 0);
        check("mid_rst_data", fc_data, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rel_ready", in_ready, 1);
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) add_beat(DW'($urandom_range(0, 1023)), i == N_IN - 1);
        run_frames(1, 0);

        // Random stream on FC_LAT=1
        gen_random(60);
        run_frames(1, -1);

        // FC_LAT=4 instance
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_IN; i++) add_beat(DW'($urandom_range(0, 1023)), i == N_IN - 1);
        run_frames(4, 0);

        // Reset during WAIT: the late result must never be captured
        for (int i = 0; i < N_IN; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom_range(0, 1023)); in_last = (i == N_IN - 1);
            wait_ready();
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("lw_fire", fc_en, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("lw_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("lw_vld", out_valid, 0);
            check("lw_result", out_result, 0);
        end

        gen_random(50);
        run_frames(4, -1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
